// File: rtl/accum_engine_if.sv
// rtl/accum_engine_if.sv - accumulator driver/receiver bundle
interface accum_engine_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] data;
  logic              enable;
  logic              clear;
  logic [DATA_W-1:0] accum;
  logic              accum_valid;
  logic              overflow;
  logic [CNT_W-1:0]  count;

  modport master (
    output data, enable, clear,
    input  accum, accum_valid, overflow, count
  );

  modport slave (
    input  data, enable, clear,
    output accum, accum_valid, overflow, count
  );
endinterface

// File: rtl/accum_engine.sv
// rtl/accum_engine.sv - pipelined running-sum accumulator with wrap/saturate overflow
module accum_engine #(
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16,
  parameter int SATURATE = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  accum_engine_if.slave  bus
);
  logic [DATA_W-1:0] s1_data;
  logic              s1_en;
  logic              s1_clr;

  logic [DATA_W-1:0] accum_q, accum_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W:0]   sum;
  logic [CNT_W-1:0]  count_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_data <= '0;
      s1_en   <= 1'b0;
      s1_clr  <= 1'b0;
    end else begin
      s1_data <= bus.data;
      s1_en   <= bus.enable;
      s1_clr  <= bus.clear;
    end
  end

  assign sum       = {1'b0, accum_q} + {1'b0, s1_data};
  assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;

  always_comb begin
    accum_d = accum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    case ({s1_clr, s1_en})
      2'b10: begin
        accum_d = '0;
        count_d = '0;
        ovf_d   = 1'b0;
        valid_d = 1'b1;
      end
      2'b11: begin
        accum_d = s1_data;
        count_d = {{(CNT_W-1){1'b0}}, 1'b1};
        ovf_d   = 1'b0;
        valid_d = 1'b1;
      end
      2'b01: begin
        count_d = count_inc;
        valid_d = 1'b1;
        accum_d = sum[DATA_W-1:0];
        if (sum[DATA_W]) begin
          ovf_d = 1'b1;
          if (SATURATE != 0) accum_d = {DATA_W{1'b1}};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accum_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      accum_q <= accum_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign bus.accum       = accum_q;
  assign bus.accum_valid = valid_q;
  assign bus.overflow    = ovf_q;
  assign bus.count       = count_q;
endmodule

// File: tb/tb_accum_engine.sv
// tb/tb_accum_engine.sv - directed self-checking bench for accum_engine
module tb_accum_engine;
  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  accum_engine_if #(.DATA_W(32), .CNT_W(16)) if0 ();
  accum_engine_if #(.DATA_W(32), .CNT_W(16)) if1 ();
  accum_engine_if #(.DATA_W(32), .CNT_W(4))  if2 ();

  accum_engine #(.DATA_W(32), .CNT_W(16), .SATURATE(0)) u_wrap (.clk(clk), .reset_n(rst0), .bus(if0));
  accum_engine #(.DATA_W(32), .CNT_W(16), .SATURATE(1)) u_sat  (.clk(clk), .reset_n(rst1), .bus(if1));
  accum_engine #(.DATA_W(32), .CNT_W(4),  .SATURATE(0)) u_cnt  (.clk(clk), .reset_n(rst2), .bus(if2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    if0.data = '0; if0.enable = 1'b0; if0.clear = 1'b0;
    if1.data = '0; if1.enable = 1'b0; if1.clear = 1'b0;
    if2.data = '0; if2.enable = 1'b0; if2.clear = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_accum", if0.accum, 0);
    check("rst_valid", if0.accum_valid, 0);
    check("rst_ovf", if0.overflow, 0);
    check("rst_count", if0.count, 0);
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;

    // basic stream 5,7,9
    @(negedge clk); if0.enable = 1'b1; if0.data = 5;
    @(negedge clk); check("lat_valid", if0.accum_valid, 0); if0.data = 7;
    @(negedge clk); check("add5", if0.accum, 5); check("add5_v", if0.accum_valid, 1);
    check("add5_cnt", if0.count, 1); if0.data = 9;
    @(negedge clk); check("add7", if0.accum, 12); check("add7_v", if0.accum_valid, 1); if0.enable = 1'b0;
    @(negedge clk); check("add9", if0.accum, 21); check("add9_v", if0.accum_valid, 1);
    check("cnt3", if0.count, 3); check("ovf0", if0.overflow, 0);
    @(negedge clk); check("idle_v", if0.accum_valid, 0); check("idle_hold", if0.accum, 21);

    // wrap overflow
    @(negedge clk); if0.clear = 1'b1; if0.enable = 1'b1; if0.data = 32'hFFFF_FFF0;
    @(negedge clk); if0.clear = 1'b0; if0.data = 32'h20;
    @(negedge clk); check("wr_load", if0.accum, 32'hFFFF_FFF0); check("wr_lcnt", if0.count, 1);
    if0.data = 1;
    @(negedge clk); if0.enable = 1'b0;
    check("wr_wrap", if0.accum, 32'h10); check("wr_ovf", if0.overflow, 1); check("wr_cnt", if0.count, 2);
    @(negedge clk); check("wr_add1", if0.accum, 32'h11); check("wr_sticky", if0.overflow, 1);

    // load then clear-only
    @(negedge clk); if0.clear = 1'b1; if0.enable = 1'b1; if0.data = 100;
    @(negedge clk); if0.data = 42;
    @(negedge clk); check("ld100", if0.accum, 100); if0.enable = 1'b0;
    @(negedge clk); if0.clear = 1'b0;
    check("ld42", if0.accum, 42); check("ld_cnt", if0.count, 1);
    check("ld_ovf", if0.overflow, 0); check("ld_v", if0.accum_valid, 1);
    @(negedge clk); check("clr_acc", if0.accum, 0); check("clr_cnt", if0.count, 0);
    check("clr_v", if0.accum_valid, 1);
    @(negedge clk); check("clr_idle_v", if0.accum_valid, 0);

    // saturating instance
    @(negedge clk); if1.clear = 1'b1; if1.enable = 1'b1; if1.data = 32'hFFFF_FFF0;
    @(negedge clk); if1.clear = 1'b0; if1.data = 32'h20;
    @(negedge clk); check("sat_load", if1.accum, 32'hFFFF_FFF0); if1.data = 0;
    @(negedge clk); if1.enable = 1'b0;
    check("sat_clamp", if1.accum, 32'hFFFF_FFFF); check("sat_ovf", if1.overflow, 1); check("sat_cnt2", if1.count, 2);
    @(negedge clk); check("sat_hold", if1.accum, 32'hFFFF_FFFF); check("sat_cnt3", if1.count, 3);
    check("sat_sticky", if1.overflow, 1);

    // asynchronous reset with a sample in flight
    @(negedge clk); if0.clear = 1'b1; if0.enable = 1'b1; if0.data = 10;
    @(negedge clk); if0.clear = 1'b0; if0.data = 20;
    @(negedge clk); check("ar_10", if0.accum, 10); if0.data = 50;
    @(negedge clk); check("ar_30", if0.accum, 30); if0.enable = 1'b0;
    #2 rst0 = 1'b0;
    #1 check("ar_acc", if0.accum, 0); check("ar_cnt", if0.count, 0);
    check("ar_ovf", if0.overflow, 0); check("ar_v", if0.accum_valid, 0);
    @(negedge clk); rst0 = 1'b1;
    @(negedge clk); check("ar_flush", if0.accum, 0); check("ar_flush_v", if0.accum_valid, 0);
    if0.enable = 1'b1; if0.data = 3;
    @(negedge clk); if0.enable = 1'b0;
    @(negedge clk); check("ar_3", if0.accum, 3); check("ar_3cnt", if0.count, 1);

    // counter saturation at CNT_W=4
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); if2.enable = 1'b1; if2.data = 1;
    end
    @(negedge clk); if2.enable = 1'b0;
    repeat (2) @(negedge clk);
    check("cs_count", if2.count, 15); check("cs_accum", if2.accum, 20); check("cs_ovf", if2.overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
